// File: rtl/ball_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ball_ctrl
// Purpose  : Pong ball position/velocity, wall and paddle bounce, scoring and
//            serve timing; advances once per frame on refresh_tick.
// Revision : 1.0 - initial release
// ============================================================================
module ball_ctrl #(
    parameter int H_MAX        = 640,
    parameter int V_MAX        = 480,
    parameter int BALL_SIZE    = 8,
    parameter int BALL_V       = 2,
    parameter int PAD_H        = 72,
    parameter int PAD1_X_L     = 32,
    parameter int PAD1_X_R     = 35,
    parameter int PAD2_X_L     = 600,
    parameter int PAD2_X_R     = 603,
    parameter int SERVE_FRAMES = 60
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       refresh_tick,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic [9:0] pad1_y,
    input  logic [9:0] pad2_y,
    input  logic       start,
    output logic       ball_on,
    output logic       score1,
    output logic       score2,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SERVE  = 2'd1;
    localparam logic [1:0] S_PLAY   = 2'd2;
    localparam logic [1:0] S_SCORED = 2'd3;

    localparam int CW = $clog2(SERVE_FRAMES + 1);

    localparam logic [9:0]    X_C        = 10'((H_MAX - BALL_SIZE) / 2);
    localparam logic [9:0]    Y_C        = 10'((V_MAX - BALL_SIZE) / 2);
    localparam logic [9:0]    STEP       = 10'(BALL_V);
    localparam logic [10:0]   SZ_M1      = 11'(BALL_SIZE - 1);
    localparam logic [10:0]   EDGE_LIM   = 11'(BALL_V);
    localparam logic [10:0]   RIGHT_LIM  = 11'(H_MAX - 1 - BALL_V);
    localparam logic [10:0]   BOTTOM_LIM = 11'(V_MAX - 1 - BALL_V);
    localparam logic [10:0]   P1_L       = 11'(PAD1_X_L);
    localparam logic [10:0]   P1_R       = 11'(PAD1_X_R);
    localparam logic [10:0]   P2_L       = 11'(PAD2_X_L);
    localparam logic [10:0]   P2_R       = 11'(PAD2_X_R);
    localparam logic [10:0]   PAD_H_M1   = 11'(PAD_H - 1);
    localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_FRAMES - 1);

    logic [1:0]    state_q,  state_d;
    logic [9:0]    bx_q,     bx_d;
    logic [9:0]    by_q,     by_d;
    logic          dx_neg_q, dx_neg_d;
    logic          dy_neg_q, dy_neg_d;
    logic [CW-1:0] cnt_q,    cnt_d;

    logic [10:0] bl, br, bt, bb;
    logic        miss_l, miss_r, hit_p1, hit_p2, wall_t, wall_b;

    assign bl = {1'b0, bx_q};
    assign br = {1'b0, bx_q} + SZ_M1;
    assign bt = {1'b0, by_q};
    assign bb = {1'b0, by_q} + SZ_M1;

    assign miss_l = dx_neg_q  && (bl <= EDGE_LIM);
    assign miss_r = !dx_neg_q && (br >= RIGHT_LIM);
    assign hit_p1 = dx_neg_q  && (bl <= P1_R) && (bl >= P1_L) &&
                    (bb >= {1'b0, pad1_y}) && (bt <= {1'b0, pad1_y} + PAD_H_M1);
    assign hit_p2 = !dx_neg_q && (br >= P2_L) && (br <= P2_R) &&
                    (bb >= {1'b0, pad2_y}) && (bt <= {1'b0, pad2_y} + PAD_H_M1);
    assign wall_t = dy_neg_q  && (bt <= EDGE_LIM);
    assign wall_b = !dy_neg_q && (bb >= BOTTOM_LIM);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            bx_q     <= X_C;
            by_q     <= Y_C;
            dx_neg_q <= 1'b0;
            dy_neg_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            bx_q     <= bx_d;
            by_q     <= by_d;
            dx_neg_q <= dx_neg_d;
            dy_neg_q <= dy_neg_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bx_d     = bx_q;
        by_d     = by_q;
        dx_neg_d = dx_neg_q;
        dy_neg_d = dy_neg_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_SERVE;
            end
            S_SERVE: begin
                bx_d = X_C;
                by_d = Y_C;
                if (refresh_tick) begin
                    if (cnt_q == SERVE_LAST) begin
                        cnt_d   = '0;
                        state_d = S_PLAY;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_PLAY: begin
                if (refresh_tick) begin
                    // The serve direction is stored in dx so the SCORED cycle
                    // can tell which player scored without an extra flag.
                    if (miss_l) begin
                        state_d  = S_SCORED;
                        dx_neg_d = 1'b1;
                    end else if (miss_r) begin
                        state_d  = S_SCORED;
                        dx_neg_d = 1'b0;
                    end else begin
                        if (hit_p1)      dx_neg_d = 1'b0;
                        else if (hit_p2) dx_neg_d = 1'b1;
                        if (wall_t)      dy_neg_d = 1'b0;
                        else if (wall_b) dy_neg_d = 1'b1;
                        bx_d = dx_neg_d ? bx_q - STEP : bx_q + STEP;
                        by_d = dy_neg_d ? by_q - STEP : by_q + STEP;
                    end
                end
            end
            S_SCORED: begin
                bx_d    = X_C;
                by_d    = Y_C;
                cnt_d   = '0;
                state_d = S_SERVE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ball_x  = bx_q;
        ball_y  = by_q;
        score2  = (state_q == S_SCORED) && dx_neg_q;
        score1  = (state_q == S_SCORED) && !dx_neg_q;
        ball_on = ({1'b0, x} >= bl) && ({1'b0, x} <= br) &&
                  ({1'b0, y} >= bt) && ({1'b0, y} <= bb);
    end

endmodule
`default_nettype wire
